// File: rtl/mrd_pkg.sv
// Shared widths, frame-checker state and sample record for the denormalizing output buffer.
package mrd_pkg;
    localparam int DATA_W  = 18;
    localparam int EXP_W   = 4;
    localparam int DPTS_W  = 12;
    localparam int SHIFT_W = 33;

    typedef enum logic {ST_IDLE, ST_IN_FRAME} frm_state_t;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
        logic                     sat;
        logic                     sop;
        logic                     eop;
        logic [DPTS_W-1:0]        dpts;
    } mrd_smp_t;

    // Returns {overflow, result}; the wide shift cannot itself overflow for exp <= 15.
    function automatic logic [DATA_W:0] denorm(input logic signed [DATA_W-1:0] v,
                                               input logic [EXP_W-1:0] e,
                                               input logic sat_en);
        logic signed [SHIFT_W-1:0] wide;
        logic                      ovf;
        logic [DATA_W-1:0]         res;
        wide = {{(SHIFT_W-DATA_W){v[DATA_W-1]}}, v};
        wide = wide << e;
        ovf  = !((&wide[SHIFT_W-1:DATA_W-1]) || (~|wide[SHIFT_W-1:DATA_W-1]));
        res  = wide[DATA_W-1:0];
        if (ovf && sat_en)
            res = wide[SHIFT_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        return {ovf, res};
    endfunction
endpackage

// File: rtl/mrd_out_denorm_fifo_if.sv
// Source-side and sink-side stream signals of the denormalizing output buffer.
interface mrd_out_denorm_fifo_if;
    import mrd_pkg::*;
    logic                     in_valid, in_ready, in_sop, in_eop;
    logic signed [DATA_W-1:0] in_real, in_imag;
    logic [EXP_W-1:0]         in_exp;
    logic [DPTS_W-1:0]        in_dftpts;
    logic                     out_valid, out_ready, out_sop, out_eop, out_sat;
    logic signed [DATA_W-1:0] out_real, out_imag;
    logic [DPTS_W-1:0]        out_dftpts;
    logic                     frame_err;

    modport slave (
        input  in_valid, in_sop, in_eop, in_real, in_imag, in_exp, in_dftpts, out_ready,
        output in_ready, out_valid, out_sop, out_eop, out_sat, out_real, out_imag,
               out_dftpts, frame_err
    );
    modport master (
        output in_valid, in_sop, in_eop, in_real, in_imag, in_exp, in_dftpts, out_ready,
        input  in_ready, out_valid, out_sop, out_eop, out_sat, out_real, out_imag,
               out_dftpts, frame_err
    );
endinterface

// File: rtl/mrd_sync_fifo.sv
// Synchronous FIFO with extra-bit pointers and a registered head-of-queue output.
module mrd_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr,
    input  logic [WIDTH-1:0]         din,
    input  logic                     rd,
    output logic [WIDTH-1:0]         dout,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             empty, full, wr_en, rd_en;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign wr_en = wr & ~full;
    assign rd_en = rd & ~empty;
    assign count = wr_ptr_q - rd_ptr_q;
    assign valid = ~empty;
    assign dout  = dout_q;

    // Preload the next head; a write landing on the head slot only happens into an empty queue.
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_en};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_en};
        dout_d   = mem_q[rd_ptr_d[AW-1:0]];
        if (wr_en && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0]))
            dout_d = din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            dout_q   <= dout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
endmodule

// File: rtl/mrd_out_denorm_fifo.sv
// Frame checker + exponent denormalization stage feeding an output FIFO.
module mrd_out_denorm_fifo
    import mrd_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter bit SAT_EN     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mrd_out_denorm_fifo_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);

    frm_state_t        state_q, state_d;
    logic [DPTS_W-1:0] cnt_q, cnt_d, dpts_q, dpts_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic              err_q, err_d, rdy_en_q;
    mrd_smp_t          stg_q, stg_d, fifo_dout;
    logic              stg_vld_q, stg_vld_d, fifo_vld, acc, fwd, hit;
    logic [AW:0]       fifo_cnt;
    logic [AW+1:0]     occ;
    logic [EXP_W-1:0]  cur_exp;
    logic [DPTS_W-1:0] cur_dpts, n_cnt;
    logic [DATA_W:0]   dn_re, dn_im;

    // The stage slot is counted so a sample in flight always has a FIFO entry waiting for it.
    assign occ          = {1'b0, fifo_cnt} + {{(AW+1){1'b0}}, stg_vld_q};
    assign bus.in_ready = rdy_en_q & (occ < (AW+2)'(FIFO_DEPTH));
    assign acc          = bus.in_valid & bus.in_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        exp_d     = exp_q;
        dpts_d    = dpts_q;
        err_d     = 1'b0;
        stg_vld_d = 1'b0;
        fwd       = 1'b0;
        cur_exp   = bus.in_sop ? bus.in_exp    : exp_q;
        cur_dpts  = bus.in_sop ? bus.in_dftpts : dpts_q;
        n_cnt     = bus.in_sop ? DPTS_W'(1)    : cnt_q + DPTS_W'(1);
        hit       = (n_cnt == cur_dpts);
        dn_re     = denorm(bus.in_real, cur_exp, SAT_EN);
        dn_im     = denorm(bus.in_imag, cur_exp, SAT_EN);
        stg_d.re   = dn_re[DATA_W-1:0];
        stg_d.im   = dn_im[DATA_W-1:0];
        stg_d.sat  = dn_re[DATA_W] | dn_im[DATA_W];
        stg_d.sop  = bus.in_sop;
        stg_d.eop  = bus.in_eop | hit;
        stg_d.dpts = cur_dpts;
        if (acc) begin
            if (bus.in_sop) begin
                fwd    = 1'b1;
                err_d  = (state_q == ST_IN_FRAME);
                exp_d  = bus.in_exp;
                dpts_d = bus.in_dftpts;
            end else if (state_q == ST_IN_FRAME) begin
                fwd = 1'b1;
            end else begin
                err_d = 1'b1;
            end
            // Frame closes on eop or on reaching its length; disagreement of the two is an error.
            if (fwd) begin
                stg_vld_d = 1'b1;
                cnt_d     = n_cnt;
                state_d   = stg_d.eop ? ST_IDLE : ST_IN_FRAME;
                if (bus.in_eop != hit)
                    err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            exp_q     <= '0;
            dpts_q    <= '0;
            err_q     <= 1'b0;
            rdy_en_q  <= 1'b0;
            stg_q     <= '0;
            stg_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            exp_q     <= exp_d;
            dpts_q    <= dpts_d;
            err_q     <= err_d;
            rdy_en_q  <= 1'b1;
            stg_q     <= stg_d;
            stg_vld_q <= stg_vld_d;
        end
    end

    mrd_sync_fifo #(.WIDTH($bits(mrd_smp_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (stg_vld_q),
        .din   (stg_q),
        .rd    (bus.out_ready),
        .dout  (fifo_dout),
        .valid (fifo_vld),
        .count (fifo_cnt)
    );

    assign bus.out_valid  = fifo_vld;
    assign bus.out_real   = fifo_dout.re;
    assign bus.out_imag   = fifo_dout.im;
    assign bus.out_sat    = fifo_dout.sat;
    assign bus.out_sop    = fifo_dout.sop;
    assign bus.out_eop    = fifo_dout.eop;
    assign bus.out_dftpts = fifo_dout.dpts;
    assign bus.frame_err  = err_q;
endmodule

// File: doc/mrd_out_denorm_fifo.md
MRD_OUT_DENORM_FIFO -- requirements
Module: mrd_out_denorm_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, output buffer depth in samples (power of 2, >=4).
REQ-002 SHALL have parameter SAT_EN, default 1, enabling saturation (1) or wrap (0) on denormalization overflow.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  sample from DFT source side valid.
REQ-006 SHALL have port in_ready  output  1  block accepts sample this cycle.
REQ-007 SHALL have ports in_sop, in_eop  input  1 each  frame start/end markers.
REQ-008 SHALL have ports in_real, in_imag  input  18 each  signed block-floating-point samples.
REQ-009 SHALL have port in_exp  input  4  frame block exponent, unsigned, sampled at in_sop.
REQ-010 SHALL have port in_dftpts  input  12  frame length, sampled at in_sop.
REQ-011 SHALL have ports out_valid, out_sop, out_eop  output  1 each  buffered stream.
REQ-012 SHALL have ports out_real, out_imag  output  18 each  denormalized signed samples.
REQ-013 SHALL have port out_sat  output  1  this sample saturated (real or imag).
REQ-014 SHALL have port out_dftpts  output  12  frame length of current output sample.
REQ-015 SHALL have port out_ready  input  1  downstream accepts.
REQ-016 SHALL have port frame_err  output  1  one-cycle pulse on framing violation.

Function
REQ-017 Input transfer SHALL occur when in_valid & in_ready; output transfer when out_valid & out_ready.
REQ-018 Accepted sample SHALL pass one register stage (denorm) then a FIFO of FIFO_DEPTH entries {real, imag, sat, sop, eop, dftpts}.
REQ-019 in_ready SHALL be 1 iff FIFO occupancy + stage-valid < FIFO_DEPTH; no accepted sample is ever lost.
REQ-020 Latency SHALL be 2 cycles: sample accepted cycle N with empty FIFO and out_ready=1 appears on out_* at cycle N+2.
REQ-021 Denorm SHALL compute value << exp in 33-bit signed; if result outside [-131072, 131071] and SAT_EN=1, clamp to that bound and set sat; SAT_EN=0 keeps low 18 bits, sat still flags overflow.
REQ-022 exp/dftpts used for a frame SHALL be those sampled at its accepted in_sop; samples without a valid frame context are dropped.
REQ-023 Frame checker FSM SHALL have states IDLE and IN_FRAME with 12-bit sample counter.
REQ-024 IDLE: sop -> IN_FRAME, count=1 (sop&eop with dftpts=1 -> stay IDLE, no error); non-sop sample -> dropped, frame_err.
REQ-025 IN_FRAME: sample -> count+1; eop with count+1==dftpts -> IDLE; eop with mismatch -> IDLE, frame_err, sample still forwarded.
REQ-026 IN_FRAME: count reaching dftpts without eop SHALL force out_eop on that sample, pulse frame_err, go IDLE.
REQ-027 IN_FRAME: new sop SHALL pulse frame_err, force out_eop on previous buffered sample is NOT required; new frame restarts with count=1 and new exp/dftpts.
REQ-028 Simultaneous FIFO write and read SHALL keep occupancy unchanged; full and empty SHALL use an extra pointer bit, wrap at FIFO_DEPTH.
REQ-029 out_* data SHALL hold stable while out_valid=1 and out_ready=0.

Reset
REQ-030 On rst_n low, immediately: out_valid, out_sop, out_eop, out_sat, frame_err=0; out_real, out_imag, out_dftpts=0; in_ready=0; FIFO pointers 0; FSM IDLE; counter 0.
REQ-031 in_ready SHALL rise the first cycle after rst_n deasserts; reset mid-frame discards all buffered and in-flight samples.

Structure
REQ-032 Shared package mrd_pkg SHALL hold data width 18, exp width 4, dftpts width 12, and the FSM state enum.
REQ-033 FIFO SHALL be a sub-module mrd_sync_fifo (parameterised width/depth, registered output); denorm and FSM in top.

Verification
REQ-034 Frame dftpts=12, exp=3, sample 1000+j0, out_ready=1 -> out 8000+j0, sop on first, eop on 12th, latency 2, frame_err never.
REQ-035 exp=4, sample 20000 / -20000 -> out 131071 / -131072, out_sat=1; SAT_EN=0 -> low 18 bits of 320000, out_sat=1.
REQ-036 out_ready=0 while sending 24-point frame, FIFO_DEPTH=16 -> in_ready falls after 16 accepted, no loss, order preserved after out_ready=1.
REQ-037 dftpts=6, eop on 4th sample -> frame_err pulse, 4 samples out with eop on 4th; then sample without sop -> dropped, frame_err.
REQ-038 rst_n low mid-frame with 5 samples buffered -> out_valid=0 at once; next frame after reset output correctly.
